// File: rtl/syn_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package syn_fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit params_ok(input int data_w, input int depth, input int fwft,
                                    input int af_thresh, input int ae_thresh);
      return (data_w >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
             ((fwft == FIFO_STD) || (fwft == FIFO_FWFT)) &&
             (af_thresh >= 1) && (af_thresh <= depth - 1) &&
             (ae_thresh >= 1) && (ae_thresh <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, read port registered or
// combinational depending on the read mode.
module fifo_ram
   import syn_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int FWFT   = FIFO_STD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [ptr_w(DEPTH)-1:0]  wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     rd_en_i,
   input  logic [ptr_w(DEPTH)-1:0]  rd_addr_i,
   output logic [DATA_W-1:0]        rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage is deliberately left out of reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   if (FWFT == FIFO_FWFT) begin : g_fwft
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = rst ^ rd_en_i;
      assign rd_data_o      = mem_q[rd_addr_i];
   end else begin : g_std
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
         end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
         end
      end
      assign rd_data_o = rd_q;
   end

endmodule

// File: rtl/syn_fifo_gen.sv
// Parametrised single-clock FIFO: pointers, occupancy, registered flags and
// overflow/underflow pulses around a fifo_ram storage array.
module syn_fifo_gen
   import syn_fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int FWFT      = FIFO_STD,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic [DATA_W-1:0]        din,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [cnt_w(DEPTH)-1:0]  data_count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   if (!params_ok(DATA_W, DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_param_err
      $error("syn_fifo_gen: illegal parameter combination");
   end

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
   logic          wr_acc, rd_acc;

   // Acceptance uses the registered flags, so rd_en/wr_en never reach a flag combinationally.
   assign wr_acc = wr_en && !full_q;
   assign rd_acc = rd_en && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CW'(DEPTH));
         empty_q  <= (count_d == '0);
         af_q     <= (count_d >= CW'(AF_THRESH));
         ae_q     <= (count_d <= CW'(AE_THRESH));
         ovf_q    <= wr_en && full_q;
         unf_q    <= rd_en && empty_q;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .FWFT   (FWFT)
   ) u_ram (
      .clk       (clk),
      .rst       (srst),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (din),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (dout)
   );

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign data_count   = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_syn_fifo_gen.sv
// Directed bench for syn_fifo_gen: a standard-read instance and an FWFT instance
// sharing clock and reset.
module tb_syn_fifo_gen;

   logic       clk;
   logic       srst;

   logic [7:0] din, dout;
   logic       wr_en, rd_en, full, empty, af, ae, ovf, unf;
   logic [4:0] dc;

   logic [7:0] f_din, f_dout;
   logic       f_wr_en, f_rd_en, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0] f_dc;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] q[$];
   logic [7:0] exp_d;
   int         cnt;
   logic       do_wr, do_rd;

   syn_fifo_gen #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
      .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
      .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
      .data_count(dc), .overflow(ovf), .underflow(unf)
   );

   syn_fifo_gen #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
      .clk(clk), .srst(srst), .din(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en), .dout(f_dout),
      .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .data_count(f_dc), .overflow(f_ovf), .underflow(f_unf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_std_reset(input string pfx);
      chk({pfx, "_dout"},  32'(dout),  32'h0);
      chk({pfx, "_empty"}, 32'(empty), 32'h1);
      chk({pfx, "_ae"},    32'(ae),    32'h1);
      chk({pfx, "_full"},  32'(full),  32'h0);
      chk({pfx, "_af"},    32'(af),    32'h0);
      chk({pfx, "_dc"},    32'(dc),    32'h0);
      chk({pfx, "_ovf"},   32'(ovf),   32'h0);
      chk({pfx, "_unf"},   32'(unf),   32'h0);
   endtask

   initial begin
      srst = 1'b1;
      din = '0; wr_en = 1'b0; rd_en = 1'b0;
      f_din = '0; f_wr_en = 1'b0; f_rd_en = 1'b0;
      #12;
      chk_std_reset("rst");
      chk("rst_f_empty", 32'(f_empty), 32'h1);
      #1 srst = 1'b0;
      tick();

      // FWFT: head visible without rd_en, next entry one cycle after the pop
      f_din = 8'h55; f_wr_en = 1'b1;
      tick();
      chk("fw_empty", 32'(f_empty), 32'h0);
      chk("fw_head55", 32'(f_dout), 32'h55);
      f_din = 8'h66;
      tick();
      f_wr_en = 1'b0;
      chk("fw_hold55", 32'(f_dout), 32'h55);
      chk("fw_dc2", 32'(f_dc), 32'h2);
      f_rd_en = 1'b1;
      tick();
      f_rd_en = 1'b0;
      chk("fw_head66", 32'(f_dout), 32'h66);
      chk("fw_dc1", 32'(f_dc), 32'h1);

      // Fill 0x00..0x0F
      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = 8'(i);
         tick();
         chk($sformatf("fill_dc%0d", i), 32'(dc), 32'(i + 1));
         chk($sformatf("fill_empty%0d", i), 32'(empty), 32'h0);
         chk($sformatf("fill_af%0d", i), 32'(af), 32'((i + 1) >= 14));
         chk($sformatf("fill_ae%0d", i), 32'(ae), 32'((i + 1) <= 2));
         chk($sformatf("fill_full%0d", i), 32'(full), 32'((i + 1) == 16));
      end

      // Overflow on full
      din = 8'hAA;
      tick();
      wr_en = 1'b0;
      chk("ovf_pulse", 32'(ovf), 32'h1);
      chk("ovf_dc", 32'(dc), 32'd16);
      tick();
      chk("ovf_clear", 32'(ovf), 32'h0);

      // Drain
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("drain_dout%0d", i), 32'(dout), 32'(i));
         chk($sformatf("drain_dc%0d", i), 32'(dc), 32'(15 - i));
      end
      chk("drain_empty", 32'(empty), 32'h1);
      tick();
      rd_en = 1'b0;
      chk("unf_pulse", 32'(unf), 32'h1);
      chk("unf_dout_hold", 32'(dout), 32'h0F);
      tick();
      chk("unf_clear", 32'(unf), 32'h0);

      // Empty + write + read
      din = 8'h11; wr_en = 1'b1; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("ewr_dc", 32'(dc), 32'h1);
      chk("ewr_unf", 32'(unf), 32'h1);
      chk("ewr_empty", 32'(empty), 32'h0);
      for (int i = 0; i < 15; i++) begin
         din = 8'(8'h20 + i);
         tick();
      end
      chk("refill_full", 32'(full), 32'h1);
      chk("refill_unf", 32'(unf), 32'h0);

      // Full + write + read
      din = 8'h99; rd_en = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("fwr_dc", 32'(dc), 32'd15);
      chk("fwr_ovf", 32'(ovf), 32'h1);
      chk("fwr_full", 32'(full), 32'h0);
      chk("fwr_dout", 32'(dout), 32'h11);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("mid_dout%0d", i), 32'(dout), 32'(8'h20 + i));
      end
      chk("mid_dc8", 32'(dc), 32'd8);

      // Count 8 + write + read
      din = 8'h77; wr_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("both8_dc", 32'(dc), 32'd8);
      chk("both8_dout", 32'(dout), 32'h27);
      chk("both8_ovf", 32'(ovf), 32'h0);

      srst = 1'b1;
      #2 srst = 1'b0;
      tick();

      // Wrap-around with interleaved traffic
      cnt = 0;
      wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 8'(8'hA0 + i);
         q.push_back(din);
         cnt++;
         tick();
         chk($sformatf("pre_ae%0d", i), 32'(ae), 32'(cnt <= 2));
      end
      for (int i = 0; i < 40; i++) begin
         do_wr = (cnt < 12) && ((i % 4) != 3);
         do_rd = (cnt > 3) && ((i % 4) != 1);
         wr_en = do_wr; rd_en = do_rd;
         din = 8'(8'h40 + i);
         exp_d = 8'h00;
         if (do_rd) exp_d = q.pop_front();
         if (do_wr) q.push_back(din);
         cnt = cnt + int'(do_wr) - int'(do_rd);
         tick();
         if (do_rd) chk($sformatf("wrap_dout%0d", i), 32'(dout), 32'(exp_d));
         chk($sformatf("wrap_dc%0d", i), 32'(dc), 32'(cnt));
         chk($sformatf("wrap_ae%0d", i), 32'(ae), 32'(cnt <= 2));
      end
      wr_en = 1'b0; rd_en = 1'b0;

      // Reset mid-operation at count 9
      srst = 1'b1;
      #2 srst = 1'b0;
      tick();
      wr_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         din = 8'(8'hC0 + i);
         tick();
      end
      wr_en = 1'b0;
      chk("pre_rst_dc9", 32'(dc), 32'd9);
      #3 srst = 1'b1;
      #1;
      chk_std_reset("midrst");
      #1 srst = 1'b0;
      din = 8'h3C; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("post_rst_dc", 32'(dc), 32'h1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("post_rst_dout", 32'(dout), 32'h3C);
      chk("post_rst_empty", 32'(empty), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
